// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble converter: binary product -> packed BCD for the display mux.
// Optional leading-zero blanking is enabled by defining BCD_LZB_EN.
module bin_to_bcd_seq #(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic                  ovf,
    output logic [4*DIGITS-1:0]   bcd_code
);

    localparam int ACC_W = 4 * (DIGITS + 1);
    localparam int OUT_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < n; i++) p = p * 64'd10;
        return p;
    endfunction

    localparam logic [63:0] LIMIT = pow10(DIGITS);

    typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;

    state_t             r_state, w_state_next;
    logic [BIN_W-1:0]   r_bin, w_bin_next;
    logic [ACC_W-1:0]   r_acc, w_acc_next;
    logic [CNT_W-1:0]   r_cnt, w_cnt_next;
    logic               r_pend, w_pend_next;
    logic [OUT_W-1:0]   r_bcd, w_bcd_next;
    logic               r_ovf, w_ovf_next;
    logic               r_done, w_done_next;
    logic               r_busy, w_busy_next;

    logic [ACC_W-1:0]       w_adj;
    logic [ACC_W+BIN_W-1:0] w_shift;
    logic [OUT_W-1:0]       w_result;
    logic                   w_ge_limit;

    assign w_ge_limit = ({{(64-BIN_W){1'b0}}, bin_in} >= LIMIT);

    // Add-3 correction on every digit, including the guard digit, in parallel.
    genvar gi;
    generate
        for (gi = 0; gi < DIGITS + 1; gi++) begin : g_adj
            assign w_adj[4*gi +: 4] = (r_acc[4*gi +: 4] >= 4'd5) ? r_acc[4*gi +: 4] + 4'd3
                                                                 : r_acc[4*gi +: 4];
        end
    endgenerate

    assign w_shift = {w_adj, r_bin} << 1;

`ifdef BCD_LZB_EN
    // Upper digits become 4'hF while they and everything above them are zero.
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_lzb
            if (gi == 0) begin : g_units
                assign w_result[3:0] = r_acc[3:0];
            end else begin : g_upper
                logic w_blank;
                assign w_blank = (r_acc[OUT_W-1:4*gi] == '0);
                assign w_result[4*gi +: 4] = w_blank ? 4'hF : r_acc[4*gi +: 4];
            end
        end
    endgenerate
`else
    assign w_result = r_acc[OUT_W-1:0];
`endif

    always_comb begin
        w_state_next = r_state;
        w_bin_next   = r_bin;
        w_acc_next   = r_acc;
        w_cnt_next   = r_cnt;
        w_pend_next  = r_pend;
        w_bcd_next   = r_bcd;
        w_ovf_next   = r_ovf;
        w_done_next  = 1'b0;
        w_busy_next  = r_busy;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_bin_next   = bin_in;
                    w_acc_next   = '0;
                    w_cnt_next   = '0;
                    w_pend_next  = w_ge_limit;
                    w_busy_next  = 1'b1;
                    w_state_next = SHIFT;
                end
            end
            SHIFT: begin
                w_acc_next = w_shift[ACC_W+BIN_W-1:BIN_W];
                w_bin_next = w_shift[BIN_W-1:0];
                w_cnt_next = r_cnt + 1'b1;
                if (r_cnt == CNT_LAST) w_state_next = FINISH;
            end
            FINISH: begin
                // Saturate to all nines; the guard digit is never shown.
                w_bcd_next   = r_pend ? {DIGITS{4'h9}} : w_result;
                w_ovf_next   = r_pend;
                w_done_next  = 1'b1;
                w_busy_next  = 1'b0;
                w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_bin   <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_pend  <= 1'b0;
            r_bcd   <= '0;
            r_ovf   <= 1'b0;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_bin   <= w_bin_next;
            r_acc   <= w_acc_next;
            r_cnt   <= w_cnt_next;
            r_pend  <= w_pend_next;
            r_bcd   <= w_bcd_next;
            r_ovf   <= w_ovf_next;
            r_done  <= w_done_next;
            r_busy  <= w_busy_next;
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign ovf      = r_ovf;
    assign bcd_code = r_bcd;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq against a decimal-arithmetic reference model.
module tb_bin_to_bcd_seq;

    logic        clk;
    logic        reset;
    logic        start;
    logic [13:0] bin_in;
    logic        busy;
    logic        done;
    logic        ovf;
    logic [15:0] bcd_code;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    bin_to_bcd_seq #(.BIN_W(14), .DIGITS(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .bin_in   (bin_in),
        .busy     (busy),
        .done     (done),
        .ovf      (ovf),
        .bcd_code (bcd_code)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    // Reference: decimal digits by division; saturate at 10^4; optional leading-zero blanking.
    function automatic logic [15:0] ref_bcd(input int v);
        logic [15:0] r;
        int ndig;
        int x;
        if (v >= 10000) return 16'h9999;
        r = '0;
        x = v;
        for (int d = 0; d < 4; d++) begin
            r[4*d +: 4] = 4'(x % 10);
            x = x / 10;
        end
`ifdef BCD_LZB_EN
        ndig = (v >= 1000) ? 4 : (v >= 100) ? 3 : (v >= 10) ? 2 : 1;
        for (int d = ndig; d < 4; d++) r[4*d +: 4] = 4'hF;
`else
        ndig = 4;
`endif
        return r;
    endfunction

    // Called at a negedge; returns at the negedge where done is seen (or on timeout).
    // lat counts posedges from and including the start edge.
    task automatic convert(input int v, output int lat, output int busy_n);
        lat = 0;
        busy_n = 0;
        start = 1'b1;
        bin_in = 14'(v);
        while (lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            start = 1'b0;
            bin_in = 14'($urandom);
            if (busy) busy_n++;
            if (done) break;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL conv_timeout bin=%0d got no done within %0d edges", v, lat);
        end
        $display("conv bin=%0d bcd=%h ovf=%b lat=%0d", v, bcd_code, ovf, lat);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        bin_in = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, ovf, bcd_code} !== 19'd0) begin
            errors++;
            $display("FAIL reset_outputs got busy=%b done=%b ovf=%b bcd=%h want all 0",
                     busy, done, ovf, bcd_code);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int lat, bn;
        convert(1234, lat, bn);
        checks++;
        if (bcd_code !== 16'h1234 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL basic_value got bcd=%h ovf=%b want 1234 ovf=0", bcd_code, ovf);
        end
        checks++;
        if (lat - 1 !== 15) begin
            errors++;
            $display("FAIL basic_latency got %0d edges want 15", lat - 1);
        end
        checks++;
        if (bn !== 15) begin
            errors++;
            $display("FAIL basic_busy_cycles got %0d want 15", bn);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || bcd_code !== 16'h1234) begin
            errors++;
            $display("FAIL basic_done_pulse got done=%b bcd=%h want done=0 bcd=1234", done, bcd_code);
        end
    endtask

    task automatic test_back_to_back();
        int lat, bn, c1, c2;
        convert(0, lat, bn);
        c1 = cyc;
        checks++;
        if (bcd_code !== ref_bcd(0) || ovf !== 1'b0) begin
            errors++;
            $display("FAIL b2b_first got bcd=%h ovf=%b want %h ovf=0", bcd_code, ovf, ref_bcd(0));
        end
        convert(9999, lat, bn);
        c2 = cyc;
        checks++;
        if (bcd_code !== 16'h9999 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL b2b_second got bcd=%h ovf=%b want 9999 ovf=0", bcd_code, ovf);
        end
        checks++;
        if (c2 - c1 !== 16) begin
            errors++;
            $display("FAIL b2b_spacing got %0d edges want 16", c2 - c1);
        end
    endtask

    task automatic test_overflow();
        int lat, bn;
        int vals[3] = '{10000, 16383, 57};
        for (int i = 0; i < 3; i++) begin
            convert(vals[i], lat, bn);
            checks++;
            if (bcd_code !== ref_bcd(vals[i]) || ovf !== (vals[i] >= 10000)) begin
                errors++;
                $display("FAIL ovf_case bin=%0d got bcd=%h ovf=%b want bcd=%h ovf=%b",
                         vals[i], bcd_code, ovf, ref_bcd(vals[i]), (vals[i] >= 10000));
            end
        end
    endtask

    task automatic test_ignore_start();
        int dones = 0;
        start = 1'b1;
        bin_in = 14'd500;
        @(posedge clk);
        for (int i = 1; i <= 35; i++) begin
            @(negedge clk);
            if (done) dones++;
            start = (i == 3 || i == 10);
            bin_in = 14'd777;
            @(posedge clk);
        end
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (dones !== 1 || bcd_code !== 16'h0500 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL ignore_start got dones=%0d bcd=%h ovf=%b want 1 0500 0", dones, bcd_code, ovf);
        end
        $display("conv bin=500 (starts of 777 while busy) bcd=%h dones=%0d", bcd_code, dones);
    endtask

    task automatic test_reset_abort();
        int lat, bn, dones;
        convert(1234, lat, bn);
        start = 1'b1;
        bin_in = 14'd4321;
        @(posedge clk);
        start = 1'b0;
        repeat (5) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({busy, done, ovf, bcd_code} !== 19'd0) begin
            errors++;
            $display("FAIL abort_async got busy=%b done=%b ovf=%b bcd=%h want all 0",
                     busy, done, ovf, bcd_code);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        dones = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) dones++;
        end
        checks++;
        if (dones !== 0 || bcd_code !== 16'h0000) begin
            errors++;
            $display("FAIL abort_no_done got dones=%0d bcd=%h want 0 0000", dones, bcd_code);
        end
        convert(4321, lat, bn);
        checks++;
        if (bcd_code !== 16'h4321 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL abort_restart got bcd=%h ovf=%b want 4321 0", bcd_code, ovf);
        end
    endtask

    task automatic test_blanking_cases();
        int lat, bn;
        int vals[4] = '{42, 0, 1005, 12000};
        for (int i = 0; i < 4; i++) begin
            convert(vals[i], lat, bn);
            checks++;
            if (bcd_code !== ref_bcd(vals[i]) || ovf !== (vals[i] >= 10000)) begin
                errors++;
                $display("FAIL lzb_case bin=%0d got bcd=%h ovf=%b want bcd=%h ovf=%b",
                         vals[i], bcd_code, ovf, ref_bcd(vals[i]), (vals[i] >= 10000));
            end
        end
    endtask

    task automatic test_random();
        int lat, bn, v;
        for (int i = 0; i < 24; i++) begin
            v = ($urandom_range(3, 0) == 0) ? int'($urandom_range(16383, 10000))
                                            : int'($urandom_range(9999, 0));
            convert(v, lat, bn);
            checks++;
            if (bcd_code !== ref_bcd(v) || ovf !== (v >= 10000) || lat !== 16) begin
                errors++;
                $display("FAIL random bin=%0d got bcd=%h ovf=%b lat=%0d want bcd=%h ovf=%b lat=16",
                         v, bcd_code, ovf, lat, ref_bcd(v), (v >= 10000));
            end
            if ($urandom_range(1, 0) == 1) repeat ($urandom_range(3, 1)) @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_overflow();
        test_ignore_start();
        test_reset_abort();
        test_blanking_cases();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bin_to_bcd_seq.md
Name: bin_to_bcd_seq

Overview:
- Sequential double-dabble (shift-add-3) converter that turns the binary multiplier product into the packed 4-digit BCD word consumed by the display multiplexer.
- Sits between the multiplier datapath and the display block.
- Uses a start/busy/done handshake.
- Holds the last result stable on bcd_code so the display refreshes continuously between conversions.

Parameters:
- BIN_W, 14, width of the binary input; one shift cycle per bit.
- DIGITS, 4, number of BCD digits in the output; bcd_code is 4*DIGITS bits.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  request a conversion of bin_in; sampled on the rising clk edge
- bin_in  input  BIN_W  unsigned binary value; captured only on an accepted start
- busy  output  1  high while a conversion is in progress
- done  output  1  one-cycle pulse when bcd_code and ovf are updated
- ovf  output  1  last converted value was >= 10^DIGITS; held until the next done
- bcd_code  output  4*DIGITS  packed BCD, digit 0 (units) in bits [3:0]; held between conversions

Behaviour:
- Interface: reset reset, asynchronous, active-high; clock clk.
- Reset forces all of the following, from any state:
  - FSM to IDLE, shift counter to 0, internal scratch to 0.
  - busy=0, done=0, ovf=0, bcd_code=0.
- FSM has three states: IDLE, SHIFT, FINISH.
- IDLE:
  - start=1 at edge k captures bin_in into the binary shift register and clears the BCD scratch accumulator.
  - The accumulator is 4*(DIGITS+1) bits wide, with one guard digit.
  - Edge k also latches ovf_pending = (bin_in >= 10^DIGITS) and moves to SHIFT. busy=1 from edge k.
- SHIFT: one iteration per edge, exactly BIN_W iterations (edges k+1 .. k+BIN_W). Each iteration:
  - Every accumulator digit >= 5 gets +3 (combinational, all digits in parallel).
  - The concatenation {accumulator, binary register} then shifts left by 1, so the binary MSB enters accumulator bit 0.
  - The counter increments. After iteration BIN_W the FSM goes to FINISH.
- FINISH, at edge k+BIN_W+1:
  - bcd_code <= low 4*DIGITS accumulator bits, or all digits 4'h9 if ovf_pending.
  - ovf <= ovf_pending, done <= 1, busy <= 0, FSM to IDLE.
- Latency: start sampled at edge k, result visible after edge k+BIN_W+1. With the defaults this is 15 cycles.
- done is high for exactly one cycle, which is an IDLE cycle. A start in that cycle is accepted normally, so back-to-back throughput is one result per BIN_W+2 cycles.
- start while busy=1 (SHIFT or FINISH) is ignored. bin_in changes while busy have no effect.
- bcd_code and ovf change only at a FINISH edge or on reset. They never show intermediate values.
- Reset mid-conversion aborts the conversion:
  - No done pulse.
  - bcd_code=0, ovf=0.
  - The next start after reset release works normally.
- Guard digit is discarded; overflow is detected only by the input compare.
- All BCD digits in the output are 0-9, except where changed by the optional feature.

Optional Feature:
- Macro: BCD_LZB_EN (leading-zero blanking).
- When defined:
  - At FINISH, each output digit from the most significant downward is replaced with 4'hF while it and all more-significant digits are zero.
  - Digit 0 is never blanked.
  - Blanking is not applied when ovf=1.
  - The display block's non-digit code path then drives those digits dark.
- When undefined: plain zero-padded BCD output; no logic for blanking is present.

Test Plan:
- Reset, then start with bin_in=1234 → busy high for 15 cycles, done pulses once, bcd_code=16'h1234, ovf=0, exactly 15 edges after the start edge.
- bin_in=0, then 9999 back-to-back, with start asserted in the done cycle → bcd_code=16'h0000, then 16'h9999; second done comes 16 edges after the first; ovf=0 both times.
- bin_in=10000, then 16383 → bcd_code=16'h9999 with ovf=1 each time. A following conversion of 57 clears ovf and gives 16'h0057.
- Start at 500, then pulse start with bin_in=777 on cycles 3 and 10 of busy → only one done, bcd_code=16'h0500; the ignored starts leave no trace.
- Reset asserted 6 cycles into a conversion of 4321, with prior bcd_code=16'h1234 → immediate busy=0, done=0, bcd_code=0, ovf=0, no done pulse. A fresh start of 4321 gives 16'h4321.
- With BCD_LZB_EN defined:
  - bin_in=42 → 16'hFF42.
  - bin_in=0 → 16'hFFF0.
  - bin_in=1005 → 16'h1005.
  - bin_in=12000 → 16'h9999 with ovf=1.
